modmul7681_arb: RTL and testbench

//  Round-robin arbiter and scheduler that shares one modmul7681s (4-cycle, non-stallable,

---
 rtl/mm7681_pkg.sv | 23 ++
 rtl/mm7681_rsp_fifo.sv | 52 +++++
 rtl/modmul7681s.sv | 31 +++
 rtl/modmul7681_arb.sv | 127 ++++++++++++
 tb/tb_modmul7681_arb.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm7681_pkg.sv
// Shared constants and the centred-residue helper for the mod-7681 multiplier datapath.
// Results are kept in the balanced range [-QHALF, QHALF].
package mm7681_pkg;
   localparam int Q       = 7681;
   localparam int W       = 13;
   localparam int MUL_LAT = 4;
   localparam int QHALF   = 3840;

   localparam logic signed [W+1:0] Q_X     = 15'sd7681;
   localparam logic signed [W+1:0] QHALF_X = 15'sd3840;

   // Maps a remainder in (-Q, Q) onto the balanced range [-QHALF, QHALF].
   function automatic logic signed [W-1:0] mm_center(input logic signed [W:0] r);
      logic signed [W+1:0] t;
      t = {r[W], r};
      if (t > QHALF_X) begin
         t = t - Q_X;
      end else if (t < -QHALF_X) begin
         t = t + Q_X;
      end
      return t[W-1:0];
   endfunction
endpackage

// File: rtl/mm7681_rsp_fifo.sv
// Show-ahead synchronous result FIFO with an occupancy count.
// Push and pop in the same cycle are both honoured at any occupancy.
module mm7681_rsp_fifo #(
   parameter int DW    = 19,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [DW-1:0]            push_data_i,
   input  logic                     pop_i,
   output logic [DW-1:0]            pop_data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q, cnt_d;
   logic          do_pop;

   assign empty_o    = (cnt_q == '0);
   assign do_pop     = pop_i & ~empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({push_i, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end
endmodule

// File: rtl/modmul7681s.sv
// Four-stage, non-stallable signed multiplier modulo 7681 with a balanced result.
// Carries no reset: the arbiter masks stale data with its own valid pipe.
module modmul7681s
   import mm7681_pkg::*;
(
   input  logic                clk,
   input  logic signed [W-1:0] inA,
   input  logic signed [W-1:0] inB,
   output logic signed [W-1:0] outC
);
   localparam logic signed [2*W-1:0] QP = 26'sd7681;

   logic signed [W-1:0]   a_q, b_q;
   logic signed [2*W-1:0] p_q;
   logic signed [2*W-1:0] rem;
   logic signed [W:0]     r_q;
   logic signed [W-1:0]   c_q;

   // Truncating remainder keeps the dividend's sign, so rem lies in (-Q, Q).
   always_comb rem = p_q % QP;

   always_ff @(posedge clk) begin
      a_q <= inA;
      b_q <= inB;
      p_q <= 26'(a_q) * 26'(b_q);
      r_q <= rem[W:0];
      c_q <= mm_center(r_q);
   end

   assign outC = c_q;
endmodule

// File: rtl/modmul7681_arb.sv
// Round-robin arbiter sharing one modmul7681s among NREQ requesters, with an
// id/tag sideband pipe and a credit-protected result FIFO.
module modmul7681_arb
   import mm7681_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int TAGW       = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int IDW       = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*W-1:0]      req_a,
   input  logic [NREQ*W-1:0]      req_b,
   input  logic [NREQ*TAGW-1:0]   req_tag,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic signed [W-1:0]    rsp_c,
   output logic [IDW-1:0]         rsp_id,
   output logic [TAGW-1:0]        rsp_tag,
   output logic                   busy
);
   localparam int DW   = W + IDW + TAGW;
   localparam int CNTW = $clog2(MUL_LAT + 1);

   logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]        sel_q, sel_d;
   logic [IDW-1:0]        gnt_idx;
   logic                  gnt_found, issue_ok, hs;
   logic [TAGW-1:0]       issue_tag;
   logic [CNTW-1:0]       inflight;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                  fifo_empty;
   logic [DW-1:0]         fifo_rdata;
   logic signed [W-1:0]   mul_a, mul_b, mul_c;

   logic                  sb_v_q   [MUL_LAT];
   logic [IDW-1:0]        sb_id_q  [MUL_LAT];
   logic [TAGW-1:0]       sb_tag_q [MUL_LAT];

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(rr_ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!gnt_found && req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(j);
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int s = 0; s < MUL_LAT; s++) inflight = inflight + CNTW'(sb_v_q[s]);
   end

   // Both terms are registered, so a pop in this cycle frees credit only next cycle.
   assign issue_ok  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
   assign hs        = gnt_found & issue_ok;
   assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      sel_d    = sel_q;
      if (hs) begin
         rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
         sel_d    = gnt_idx;
      end
   end

   // Operand mux follows the grant on a handshake and otherwise parks on the last issuer.
   assign mul_a     = req_a[int'(sel_d)*W +: W];
   assign mul_b     = req_b[int'(sel_d)*W +: W];
   assign issue_tag = req_tag[int'(gnt_idx)*TAGW +: TAGW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         sel_q    <= '0;
         for (int s = 0; s < MUL_LAT; s++) begin
            sb_v_q[s]   <= 1'b0;
            sb_id_q[s]  <= '0;
            sb_tag_q[s] <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         sel_q       <= sel_d;
         sb_v_q[0]   <= hs;
         sb_id_q[0]  <= gnt_idx;
         sb_tag_q[0] <= issue_tag;
         for (int s = 1; s < MUL_LAT; s++) begin
            sb_v_q[s]   <= sb_v_q[s-1];
            sb_id_q[s]  <= sb_id_q[s-1];
            sb_tag_q[s] <= sb_tag_q[s-1];
         end
      end
   end

   modmul7681s u_mul (
      .clk  (clk),
      .inA  (mul_a),
      .inB  (mul_b),
      .outC (mul_c)
   );

   mm7681_rsp_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (sb_v_q[MUL_LAT-1]),
      .push_data_i ({mul_c, sb_id_q[MUL_LAT-1], sb_tag_q[MUL_LAT-1]}),
      .pop_i       (rsp_ready),
      .pop_data_o  (fifo_rdata),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign rsp_valid = ~fifo_empty;
   assign rsp_c     = fifo_rdata[DW-1 -: W];
   assign rsp_id    = fifo_rdata[TAGW +: IDW];
   assign rsp_tag   = fifo_rdata[TAGW-1:0];
   assign busy      = (inflight != '0) | ~fifo_empty;
endmodule

// File: tb/tb_modmul7681_arb.sv
// Directed bench for modmul7681_arb: grant order, latency, credit, arithmetic and reset.
module tb_modmul7681_arb;
   localparam int NREQ = 4;
   localparam int TAGW = 4;
   localparam int W    = 13;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*W-1:0]     req_a, req_b;
   logic [NREQ*TAGW-1:0]  req_tag;
   logic                  rsp_valid, rsp_ready;
   logic signed [W-1:0]   rsp_c;
   logic [1:0]            rsp_id;
   logic [TAGW-1:0]       rsp_tag;
   logic                  busy;

   int errors = 0;
   int checks = 0;

   modmul7681_arb #(.NREQ(NREQ), .TAGW(TAGW), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_c     (rsp_c),
      .rsp_id    (rsp_id),
      .rsp_tag   (rsp_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Credit invariant: never a push into a full FIFO without a same-cycle pop.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (dut.u_fifo.count_o == 4'd8 && dut.u_fifo.push_i && !dut.u_fifo.pop_i) begin
            errors++;
            $display("FAIL push_while_full: count=%0d push=1 pop=0 required no push", dut.u_fifo.count_o);
         end
         if (dut.u_fifo.count_o > 4'd8) begin
            errors++;
            $display("FAIL fifo_count_bound: count=%0d required <= 8", dut.u_fifo.count_o);
         end
      end
   end

   task automatic set_req(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                          input logic [TAGW-1:0] t);
      req_a[i*W +: W]       = a;
      req_b[i*W +: W]       = b;
      req_tag[i*TAGW +: TAGW] = t;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_tag   = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      req_valid = 4'b1010;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_rr_ptr_zero: got %b want 0010", req_ready); end
   endtask

   task automatic test_single();
      do_reset();
      rsp_ready = 1'b1;
      set_req(0, 13'sd2, 13'sd3, 4'd5);
      req_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== (n == 5)) begin
            errors++; $display("FAIL single_latency c%0d: rsp_valid=%b want %b", n, rsp_valid, (n == 5));
         end
         checks++;
         if (busy !== (n <= 5)) begin
            errors++; $display("FAIL single_busy c%0d: busy=%b want %b", n, busy, (n <= 5));
         end
         if (n == 5) begin
            checks++;
            if (rsp_c !== 13'sd6 || rsp_id !== 2'd0 || rsp_tag !== 4'd5) begin
               errors++; $display("FAIL single_data: c=%0d id=%0d tag=%0d want 6/0/5", rsp_c, rsp_id, rsp_tag);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 13'(i + 1), 13'sd10, 4'(10 + i));
      req_valid = 4'b1111;
      for (int cyc = 0; cyc <= 17; cyc++) begin
         @(negedge clk);
         if (cyc <= 11) begin
            checks++;
            if (req_ready !== (4'b0001 << (cyc % 4))) begin
               errors++; $display("FAIL rr_grant c%0d: got %b want %b", cyc, req_ready, 4'b0001 << (cyc % 4));
            end
         end
         if (cyc >= 5 && cyc <= 16) begin
            int id;
            id = (cyc - 5) % 4;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_c !== 13'((id + 1) * 10) || rsp_tag !== 4'(10 + id)) begin
               errors++;
               $display("FAIL rr_rsp c%0d: v=%b id=%0d c=%0d tag=%0d want 1/%0d/%0d/%0d",
                        cyc, rsp_valid, rsp_id, rsp_c, rsp_tag, id, (id + 1) * 10, 10 + id);
            end
         end
         if (cyc == 17) begin
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: rsp_valid=%b want 0", rsp_valid); end
         end
         @(posedge clk); #1;
         if (cyc == 11) req_valid = '0;
      end
   endtask

   task automatic test_credit();
      int n_iss;
      logic [3:0] exp_rdy;
      do_reset();
      n_iss = 0;
      set_req(1, 13'sd1, 13'sd3, 4'd0);
      req_valid = 4'b0010;
      for (int cyc = 0; cyc <= 23; cyc++) begin
         @(negedge clk);
         exp_rdy = (cyc < 8 || cyc == 15) ? 4'b0010 : 4'b0000;
         if (cyc <= 15) begin
            checks++;
            if (req_ready !== exp_rdy) begin
               errors++; $display("FAIL credit_ready c%0d: got %b want %b", cyc, req_ready, exp_rdy);
            end
         end
         if (cyc == 13) begin
            checks++;
            if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
               errors++; $display("FAIL credit_full: rsp_valid=%b busy=%b want 1/1", rsp_valid, busy);
            end
         end
         if (cyc >= 14 && cyc <= 22) begin
            int n;
            n = cyc - 14;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 13'((n + 1) * 3) || rsp_tag !== 4'(n)) begin
               errors++;
               $display("FAIL credit_rsp c%0d: v=%b id=%0d c=%0d tag=%0d want 1/1/%0d/%0d",
                        cyc, rsp_valid, rsp_id, rsp_c, rsp_tag, (n + 1) * 3, n);
            end
         end
         if (cyc == 23) begin
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
               errors++; $display("FAIL credit_drained: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
            end
         end
         @(posedge clk); #1;
         if (exp_rdy != 4'b0000 && cyc <= 15) begin
            n_iss++;
            set_req(1, 13'(n_iss + 1), 13'sd3, 4'(n_iss));
         end
         if (cyc == 13) rsp_ready = 1'b1;
         if (cyc == 15) req_valid = '0;
      end
   endtask

   task automatic test_arith();
      int va[5] = '{-3840, 100, 3840, 0, -1};
      int vb[5] = '{-3840, 77, 1, -17, -1};
      int ve[5] = '{-1920, 19, 3840, 0, 1};
      do_reset();
      rsp_ready = 1'b1;
      set_req(2, 13'(va[0]), 13'(vb[0]), 4'd0);
      req_valid = 4'b0100;
      for (int cyc = 0; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (cyc < 5) begin
            checks++;
            if (req_ready !== 4'b0100) begin errors++; $display("FAIL arith_grant c%0d: got %b want 0100", cyc, req_ready); end
         end else if (cyc < 10) begin
            int k;
            logic signed [W-1:0] ec;
            k  = cyc - 5;
            ec = 13'(ve[k]);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_c !== ec || rsp_id !== 2'd2 || rsp_tag !== 4'(k)) begin
               errors++;
               $display("FAIL arith_%0d: v=%b c=%0d id=%0d tag=%0d want 1/%0d/2/%0d",
                        k, rsp_valid, rsp_c, rsp_id, rsp_tag, ve[k], k);
            end
         end else begin
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arith_drained: rsp_valid=%b want 0", rsp_valid); end
         end
         @(posedge clk); #1;
         if (cyc < 4) set_req(2, 13'(va[cyc + 1]), 13'(vb[cyc + 1]), 4'(cyc + 1));
         if (cyc == 4) req_valid = '0;
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      set_req(3, 13'sd7, 13'sd2, 4'd9);
      req_valid = 4'b1000;
      for (int cyc = 0; cyc <= 5; cyc++) begin
         @(negedge clk);
         if (cyc == 5) begin
            checks++;
            if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
               errors++; $display("FAIL midop_pre: rsp_valid=%b busy=%b want 1/1", rsp_valid, busy);
            end
         end
         @(posedge clk); #1;
         if (cyc == 4) req_valid = '0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midop_async: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
      end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midop_residue c%0d: rsp_valid=%b busy=%b want 0/0", cyc, rsp_valid, busy);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_credit();
      test_arith();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
